// File: rtl/sqrt_req_arbiter_pkg.sv
// Shared constants and helpers for the sqrt request arbiter.
package sqrt_req_arbiter_pkg;

    localparam int SQRT_LATENCY = 17;
    localparam int MAX_REQ      = 32;

    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-robin pick: first set bit after `last`, wrapping at n; -1 if none.
    function automatic int rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int                 last,
        input int                 n
    );
        int                 res;
        int                 idx;
        logic [MAX_REQ-1:0] sh;
        res = -1;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = (last + i) % n;
            sh  = req >> idx;
            if (i <= n && res < 0 && sh[0]) begin
                res = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO of arbitrary depth; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO may still take a push when it is popped the same cycle.
    assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= bump(wptr);
            end
            if (do_pop) begin
                rptr <= bump(rptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_req_arbiter.sv
// Round-robin sharing of one sqrt pipeline among NUM_REQ requesters,
// with credit-limited per-requester response buffers.
module sqrt_req_arbiter
    import sqrt_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 16,
    parameter int LATENCY   = SQRT_LATENCY,
    parameter int RSP_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [WIDTH-1:0]         sqrt_N,
    output logic                     sqrt_in_valid,
    input  logic [WIDTH-1:0]         sqrt_result,
    input  logic                     sqrt_out_valid,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [NUM_REQ*WIDTH-1:0] rsp_data,
    output logic                     err_orphan
);

    localparam int TAG_W = tag_width(NUM_REQ);
    localparam int CW    = $clog2(RSP_DEPTH + 1);
    localparam int DW    = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(RSP_DEPTH);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [MAX_REQ-1:0] cand;
    int                 pick;
    logic               accept;
    logic [TAG_W-1:0]   win;
    logic [TAG_W-1:0]   last_q;
    logic [DW-1:0]      drain_q;
    logic               drained;
    logic               tag_empty;
    logic               tag_pop;
    logic [TAG_W-1:0]   tag_head;

    assign drained = (drain_q == '0);

    always_comb begin
        cand                = '0;
        cand[NUM_REQ-1:0]   = drained ? eligible : '0;
        pick                = rr_pick(cand, int'(last_q), NUM_REQ);
        accept              = (pick >= 0);
        grant               = '0;
        sqrt_N              = '0;
        if (accept) begin
            grant  = NUM_REQ'(1) << pick;
            sqrt_N = WIDTH'(req_data >> (pick * WIDTH));
        end
    end

    assign win           = TAG_W'(pick);
    assign req_ready     = grant;
    assign sqrt_in_valid = accept;

    // Results landing before the pipeline has flushed belong to nobody.
    assign tag_pop = sqrt_out_valid && !tag_empty && drained;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= TAG_W'(NUM_REQ - 1);
            drain_q    <= DW'(LATENCY);
            err_orphan <= 1'b0;
        end else begin
            if (accept) begin
                last_q <= win;
            end
            if (!drained) begin
                drain_q <= drain_q - 1'b1;
            end
            if (sqrt_out_valid && tag_empty && drained) begin
                err_orphan <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (LATENCY + 1)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (win),
        .pop   (tag_pop),
        .rdata (tag_head),
        .empty (tag_empty)
    );

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
        logic [CW-1:0]    credit;
        logic             rsp_push;
        logic             rsp_pop;
        logic             rsp_empty;
        logic [WIDTH-1:0] rsp_head;

        assign rsp_push    = tag_pop && (tag_head == TAG_W'(k));
        assign rsp_pop     = !rsp_empty && rsp_ready[k];
        assign eligible[k] = req_valid[k] && (credit < CRED_MAX);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                credit <= '0;
            end else if (grant[k] && !rsp_pop) begin
                credit <= credit + 1'b1;
            end else if (rsp_pop && !grant[k]) begin
                credit <= credit - 1'b1;
            end
        end

        sync_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (RSP_DEPTH)
        ) u_rsp_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (rsp_push),
            .wdata (sqrt_result),
            .pop   (rsp_pop),
            .rdata (rsp_head),
            .empty (rsp_empty)
        );

        assign rsp_valid[k]                 = !rsp_empty;
        assign rsp_data[k*WIDTH +: WIDTH]   = rsp_empty ? '0 : rsp_head;
    end

endmodule

// File: tb/tb_sqrt_req_arbiter.sv
// Directed bench for sqrt_req_arbiter with a behavioural Q.6 sqrt pipeline.
module tb_sqrt_req_arbiter;

    localparam int NR  = 4;
    localparam int W   = 16;
    localparam int LAT = 17;
    localparam int RD  = 2;

    localparam logic [W-1:0] EXP_N  [4] = '{16'd1, 16'd4, 16'd9, 16'd25};
    localparam logic [W-1:0] EXP_Q6 [4] = '{16'h0040, 16'h0080, 16'h00C0, 16'h0140};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_data = '0;
    logic [W-1:0]    sqrt_N;
    logic            sqrt_in_valid;
    logic [W-1:0]    sqrt_result;
    logic            sqrt_out_valid;
    logic [NR-1:0]   rsp_valid;
    logic [NR-1:0]   rsp_ready = '0;
    logic [NR*W-1:0] rsp_data;
    logic            err_orphan;
    logic            inj_ov = 1'b0;

    logic [LAT-1:0]  pv = '0;
    logic [W-1:0]    pd [LAT];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sqrt_req_arbiter #(
        .NUM_REQ   (NR),
        .WIDTH     (W),
        .LATENCY   (LAT),
        .RSP_DEPTH (RD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .sqrt_N         (sqrt_N),
        .sqrt_in_valid  (sqrt_in_valid),
        .sqrt_result    (sqrt_result),
        .sqrt_out_valid (sqrt_out_valid),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .err_orphan     (err_orphan)
    );

    // sqrt(N) in Q.6 == floor(sqrt(N * 4096))
    function automatic logic [W-1:0] isqrt_q6(input logic [W-1:0] n);
        logic [31:0] v;
        logic [31:0] r;
        logic [31:0] t;
        v = {4'b0, n, 12'b0};
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if (t * t <= v) r = t;
        end
        return r[W-1:0];
    endfunction

    // Unreset pipeline model of the sqrt unit.
    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], sqrt_in_valid};
        pd[0] <= isqrt_q6(sqrt_N);
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end

    assign sqrt_out_valid = pv[LAT-1] | inj_ov;
    assign sqrt_result    = pd[LAT-1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = '0;
        req_data  = '0;
        inj_ov    = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        req_data  = {16'd9, 16'd4, 16'd1, 16'd16};
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
        checks++; if (sqrt_in_valid !== 1'b0) begin failures++; $display("FAIL rst_in_valid got %b want 0", sqrt_in_valid); end
        checks++; if (sqrt_N !== 16'h0) begin failures++; $display("FAIL rst_sqrt_N got %h want 0000", sqrt_N); end
        checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL rst_rsp_valid got %b want 0000", rsp_valid); end
        checks++; if (rsp_data !== 64'h0) begin failures++; $display("FAIL rst_rsp_data got %h want 0", rsp_data); end
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL rst_orphan got %b want 0", err_orphan); end
        rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            #1;
            checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL drain_block cyc=%0d got %b want 0000", i, req_ready); end
            @(negedge clk);
        end
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL drain_open got %b want 0001", req_ready); end
        checks++; if (sqrt_in_valid !== 1'b1) begin failures++; $display("FAIL drain_open_iv got %b want 1", sqrt_in_valid); end
        checks++; if (sqrt_N !== 16'd16) begin failures++; $display("FAIL drain_open_N got %h want 0010", sqrt_N); end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_single();
        do_reset();
        req_data[15:0] = 16'd16;
        req_valid      = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got %b want 0001", req_ready); end
        checks++; if (sqrt_in_valid !== 1'b1) begin failures++; $display("FAIL single_iv got %b want 1", sqrt_in_valid); end
        checks++; if (sqrt_N !== 16'd16) begin failures++; $display("FAIL single_N got %h want 0010", sqrt_N); end
        @(negedge clk);
        req_valid = '0;
        for (int i = 1; i <= LAT; i++) begin
            #1;
            checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL single_early cyc=%0d got %b want 0000", i, rsp_valid); end
            @(negedge clk);
        end
        #1;
        checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL single_rsp_valid got %b want 0001", rsp_valid); end
        checks++; if (rsp_data[15:0] !== 16'h0100) begin failures++; $display("FAIL single_rsp_data got %h want 0100", rsp_data[15:0]); end
        rsp_ready = 4'b0001;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL single_pop got %b want 0000", rsp_valid); end
        rsp_ready = '0;
    endtask

    task automatic test_zero();
        int n;
        do_reset();
        req_data[15:0] = 16'd0;
        req_valid      = 4'b0001;
        #1;
        checks++; if (sqrt_in_valid !== 1'b1) begin failures++; $display("FAIL zero_iv got %b want 1", sqrt_in_valid); end
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < LAT + 5) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++; if (rsp_valid[0] !== 1'b1) begin failures++; $display("FAIL zero_timeout got %b want 1", rsp_valid[0]); end
        checks++; if (rsp_data[15:0] !== 16'h0) begin failures++; $display("FAIL zero_data got %h want 0000", rsp_data[15:0]); end
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] want;
        logic [W-1:0]  got;
        do_reset();
        req_data  = {16'd25, 16'd9, 16'd4, 16'd1};
        req_valid = '1;
        rsp_ready = '1;
        for (int i = 0; i < 26; i++) begin
            #1;
            if (i < 8) begin
                want = 4'(1 << (i % 4));
                checks++; if (req_ready !== want) begin failures++; $display("FAIL rr_grant cyc=%0d got %b want %b", i, req_ready, want); end
                checks++; if (sqrt_in_valid !== 1'b1) begin failures++; $display("FAIL rr_iv cyc=%0d got %b want 1", i, sqrt_in_valid); end
                checks++; if (sqrt_N !== EXP_N[2'(i % 4)]) begin failures++; $display("FAIL rr_N cyc=%0d got %h want %h", i, sqrt_N, EXP_N[2'(i % 4)]); end
            end else if (i <= 18) begin
                checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL rr_credit_block cyc=%0d got %b want 0000", i, req_ready); end
            end else if (i <= 22) begin
                want = 4'(1 << ((i - 19) % 4));
                checks++; if (req_ready !== want) begin failures++; $display("FAIL rr_resume cyc=%0d got %b want %b", i, req_ready, want); end
            end
            if (i < 18) begin
                checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL rr_rsp_early cyc=%0d got %b want 0000", i, rsp_valid); end
            end else begin
                want = 4'(1 << ((i - 18) % 4));
                got  = 16'(rsp_data >> (((i - 18) % 4) * 16));
                checks++; if (rsp_valid !== want) begin failures++; $display("FAIL rr_rsp_valid cyc=%0d got %b want %b", i, rsp_valid, want); end
                checks++; if (got !== EXP_Q6[2'((i - 18) % 4)]) begin failures++; $display("FAIL rr_rsp_data cyc=%0d got %h want %h", i, got, EXP_Q6[2'((i - 18) % 4)]); end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int acc;
        do_reset();
        req_data[47:32] = 16'd4;
        req_valid       = 4'b0100;
        rsp_ready       = '0;
        acc = 0;
        for (int i = 0; i < 27; i++) begin
            #1;
            if (req_ready[2]) acc++;
            if (i < 2) begin
                checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_accept cyc=%0d got %b want 0100", i, req_ready); end
            end else begin
                checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL bp_block cyc=%0d got %b want 0000", i, req_ready); end
            end
            if (i == 19) begin
                checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL bp_buffered got %b want 0100", rsp_valid); end
            end
            if (i == 26) rsp_ready = 4'b0100;
            @(negedge clk);
        end
        rsp_ready = '0;
        #1;
        checks++; if (acc !== 2) begin failures++; $display("FAIL bp_accepts got %0d want 2", acc); end
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_release got %b want 0100", req_ready); end
        checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL bp_remaining got %b want 0100", rsp_valid); end
        checks++; if (rsp_data[47:32] !== 16'h0080) begin failures++; $display("FAIL bp_data got %h want 0080", rsp_data[47:32]); end
        req_valid = '0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_data  = {16'd25, 16'd9, 16'd4, 16'd1};
        req_valid = '1;
        rsp_ready = '1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (sqrt_in_valid !== 1'b1) begin failures++; $display("FAIL mid_issue cyc=%0d got %b want 1", i, sqrt_in_valid); end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '1;
        for (int i = 0; i < LAT + 8; i++) begin
            #1;
            if (i < LAT) begin
                checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL mid_drain cyc=%0d got %b want 0000", i, req_ready); end
            end
            if (i == LAT) begin
                checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_open got %b want 0001", req_ready); end
                req_valid = '0;
            end
            checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL mid_stale cyc=%0d got %b want 0000", i, rsp_valid); end
            @(negedge clk);
        end
        #1;
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL mid_orphan got %b want 0", err_orphan); end
        rsp_ready = '0;
    endtask

    task automatic test_orphan();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        inj_ov = 1'b1;
        @(negedge clk);
        inj_ov = 1'b0;
        #1;
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL orphan_in_drain got %b want 0", err_orphan); end
        repeat (LAT - 4) @(negedge clk);
        inj_ov = 1'b1;
        #1;
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL orphan_before got %b want 0", err_orphan); end
        @(negedge clk);
        inj_ov = 1'b0;
        #1;
        checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_set got %b want 1", err_orphan); end
        checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL orphan_rsp got %b want 0000", rsp_valid); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky got %b want 1", err_orphan); end
        rst_n = 1'b0;
        #1;
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL orphan_clear got %b want 0", err_orphan); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_orphan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
